// File: rtl/control_contador.sv
// control_contador -- run controller for a 4-bit enable-driven counter.
//
// Drives the counter's enable at a prescaled rate (one step per DIV clocks)
// from the accepted start until the counter output matches the latched target.
// It then pulses done for one cycle and returns to idle. It never loads or
// resets the counter; it only owns the enable line and watches the count.
//
// Parameters:
//   DIV      prescale ratio, 1..65535 (one count step per DIV clocks in RUN)
//
// Ports:
//   clk      rising-edge clock shared with the counter
//   rst      synchronous active-high reset
//   start    run request, honoured in IDLE only
//   limite   target count, latched when start is accepted
//   pausa    level; holds the run while high
//   abortar  cancels a run (RUN/PAUSE) without a done pulse
//   c        counter output fed back from the counter
//   paso     single-step request in PAUSE (only with CONTROL_CONTADOR_STEP_EN)
//   en       counter enable, decoded from registered state
//   busy     high in RUN or PAUSE
//   done     one-cycle completion pulse
//
// Build option: define CONTROL_CONTADOR_STEP_EN to add the paso input and
// single-step support while paused.

module control_contador #(
   parameter int DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] limite,
   input  logic       pausa,
   input  logic       abortar,
   input  logic [3:0] c,
`ifdef CONTROL_CONTADOR_STEP_EN
   input  logic       paso,
`endif
   output logic       en,
   output logic       busy,
   output logic       done
);

   localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [3:0]  lim_q;
   logic [15:0] pre_q;
   logic        tick;
   logic        at_lim;

   assign tick   = (pre_q == DIV_M1);
   assign at_lim = (c == lim_q);

   // Main controller. The prescaler only advances on edges where the FSM is
   // in RUN, so its phase is kept intact across a pause.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         lim_q <= 4'd0;
         pre_q <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  lim_q <= limite;
                  pre_q <= 16'd0;
               end
            end
            RUN: begin
               pre_q <= tick ? 16'd0 : pre_q + 16'd1;
               if (abortar)
                  state <= IDLE;
               else if (at_lim)
                  state <= DONE;
               else if (pausa)
                  state <= PAUSE;
            end
            PAUSE: begin
               if (abortar)
                  state <= IDLE;
               else if (!pausa)
                  state <= RUN;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CONTROL_CONTADOR_STEP_EN
   // Single step: a rising edge of paso seen while paused arms step_q, which
   // issues exactly one enable cycle on the following clock.
   logic paso_d;
   logic step_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         paso_d <= 1'b0;
         step_q <= 1'b0;
      end else begin
         paso_d <= paso;
         step_q <= (state == PAUSE) && paso && !paso_d;
      end
   end
`endif

   // Enable is gated by the live comparison so the step that lands on the
   // target drops en in the same cycle: no overshoot.
   always_comb begin
      en = 1'b0;
      if (state == RUN)
         en = tick && !at_lim;
`ifdef CONTROL_CONTADOR_STEP_EN
      else if (state == PAUSE)
         en = step_q && !at_lim;
`endif
   end

   assign busy = (state == RUN) || (state == PAUSE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_control_contador.sv
// Testbench for control_contador. Three controllers (DIV = 1, 2, 4) each drive
// their own behavioural 4-bit counter. DIV=1 is exercised by a vector table;
// prescaled runs, pause, abort, reset and stepping use hand-written sequences.

module tb_control_contador;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start2, start4;
   logic [3:0] limite;
   logic       pausa;
   logic       abortar;
   logic       paso;
   logic       ld;
   logic [3:0] ld_val;
   logic [3:0] c1, c2, c4;
   logic       en1, en2, en4;
   logic       busy1, busy2, busy4;
   logic       done1, done2, done4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   control_contador #(.DIV(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .limite(limite), .pausa(pausa),
      .abortar(abortar), .c(c1),
`ifdef CONTROL_CONTADOR_STEP_EN
      .paso(paso),
`endif
      .en(en1), .busy(busy1), .done(done1));

   control_contador #(.DIV(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .limite(limite), .pausa(pausa),
      .abortar(abortar), .c(c2),
`ifdef CONTROL_CONTADOR_STEP_EN
      .paso(paso),
`endif
      .en(en2), .busy(busy2), .done(done2));

   control_contador #(.DIV(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .limite(limite), .pausa(pausa),
      .abortar(abortar), .c(c4),
`ifdef CONTROL_CONTADOR_STEP_EN
      .paso(paso),
`endif
      .en(en4), .busy(busy4), .done(done4));

   // Behavioural counters: increment on the edge that samples en, loadable
   // by the bench only, unaffected by the controller reset.
   always_ff @(posedge clk) begin
      if (ld) begin
         c1 <= ld_val;
         c2 <= ld_val;
         c4 <= ld_val;
      end else begin
         if (en1) c1 <= c1 + 4'd1;
         if (en2) c2 <= c2 + 4'd1;
         if (en4) c4 <= c4 + 4'd1;
      end
   end

   typedef struct {
      logic       ld;
      logic [3:0] ldv;
      logic       start;
      logic [3:0] lim;
      logic       pausa;
      logic       abortar;
      logic       e_en;
      logic       e_busy;
      logic       e_done;
      logic [3:0] e_c;
      string      tag;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic l, input logic [3:0] lv, input logic s,
                               input logic [3:0] lm, input logic p, input logic a,
                               input logic e, input logic b, input logic d,
                               input logic [3:0] cc, input string t);
      vec_t v;
      v.ld = l; v.ldv = lv; v.start = s; v.lim = lm; v.pausa = p; v.abortar = a;
      v.e_en = e; v.e_busy = b; v.e_done = d; v.e_c = cc; v.tag = t;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_c(input logic [3:0] v);
      ld = 1'b1;
      ld_val = v;
      step();
      ld = 1'b0;
   endtask

   // One comparison of the packed {en, busy, done, c} observation.
   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_vec++;
      $display("vec %0d %s: en=%b busy=%b done=%b c=%0d", n_vec, name,
               act[6], act[5], act[4], act[3:0]);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got en/busy/done/c=%b required %b", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start1 = 0; start2 = 0; start4 = 0; limite = 0;
      pausa = 0; abortar = 0; paso = 0; ld = 0; ld_val = 0;

      // ---- reset state ----
      step();
      step();
      chk("reset_div1", {en1, busy1, done1, 4'd0}, 7'b000_0000);
      chk("reset_div2", {en2, busy2, done2, 4'd0}, 7'b000_0000);
      chk("reset_div4", {en4, busy4, done4, 4'd0}, 7'b000_0000);
      rst = 1'b0;
      step();

      // ---- DIV=1 vector table ----
      //                 ld ldv st lim pa ab  en bu dn c
      tbl.push_back(mk(1, 3,  1, 9,  0, 0,  1, 1, 0, 3,  "basic0"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  1, 1, 0, 4,  "basic1_limchg"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  1, 1, 0, 5,  "basic2"));
      tbl.push_back(mk(0, 0,  1, 4,  0, 0,  1, 1, 0, 6,  "basic3_startign"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  1, 1, 0, 7,  "basic4"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  1, 1, 0, 8,  "basic5"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  0, 1, 0, 9,  "basic6_atlim"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0, 1, 9,  "basic7_done"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 9,  "basic8_idle"));
      tbl.push_back(mk(1, 5,  1, 5,  0, 1,  0, 1, 0, 5,  "zero0_startabort"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0, 1, 5,  "zero1_done"));
      tbl.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 5,  "zero2_idle"));
      tbl.push_back(mk(1, 0,  1, 2,  0, 0,  1, 1, 0, 0,  "abtc0"));
      tbl.push_back(mk(0, 0,  0, 2,  0, 0,  1, 1, 0, 1,  "abtc1"));
      tbl.push_back(mk(0, 0,  0, 2,  0, 0,  0, 1, 0, 2,  "abtc2_atlim"));
      tbl.push_back(mk(0, 0,  0, 2,  0, 1,  0, 0, 0, 2,  "abtc3_abort"));
      tbl.push_back(mk(0, 0,  0, 2,  0, 0,  0, 0, 0, 2,  "abtc4_nodone"));
      tbl.push_back(mk(1, 0,  1, 1,  0, 0,  1, 1, 0, 0,  "cbp0"));
      tbl.push_back(mk(0, 0,  0, 1,  0, 0,  0, 1, 0, 1,  "cbp1_atlim"));
      tbl.push_back(mk(0, 0,  0, 1,  1, 0,  0, 0, 1, 1,  "cbp2_donewins"));
      tbl.push_back(mk(0, 0,  0, 1,  1, 0,  0, 0, 0, 1,  "cbp3_idle"));
      tbl.push_back(mk(1, 15, 1, 1,  0, 0,  1, 1, 0, 15, "wrap0"));
      tbl.push_back(mk(0, 0,  0, 1,  0, 0,  1, 1, 0, 0,  "wrap1"));
      tbl.push_back(mk(0, 0,  0, 1,  0, 0,  0, 1, 0, 1,  "wrap2_atlim"));
      tbl.push_back(mk(0, 0,  0, 1,  0, 0,  0, 0, 1, 1,  "wrap3_done"));
      tbl.push_back(mk(0, 0,  0, 1,  0, 0,  0, 0, 0, 1,  "wrap4_idle"));
      tbl.push_back(mk(1, 0,  1, 3,  0, 0,  1, 1, 0, 0,  "pz0"));
      tbl.push_back(mk(0, 0,  0, 3,  1, 0,  0, 1, 0, 1,  "pz1_pause"));
      tbl.push_back(mk(0, 0,  0, 3,  1, 0,  0, 1, 0, 1,  "pz2_hold"));
      tbl.push_back(mk(0, 0,  0, 3,  0, 0,  1, 1, 0, 1,  "pz3_resume"));
      tbl.push_back(mk(0, 0,  0, 3,  0, 0,  1, 1, 0, 2,  "pz4"));
      tbl.push_back(mk(0, 0,  0, 3,  0, 0,  0, 1, 0, 3,  "pz5_atlim"));
      tbl.push_back(mk(0, 0,  0, 3,  0, 0,  0, 0, 1, 3,  "pz6_done"));
      tbl.push_back(mk(0, 0,  0, 3,  0, 0,  0, 0, 0, 3,  "pz7_idle"));

      foreach (tbl[i]) begin
         if (tbl[i].ld) load_c(tbl[i].ldv);
         start1  = tbl[i].start;
         limite  = tbl[i].lim;
         pausa   = tbl[i].pausa;
         abortar = tbl[i].abortar;
         step();
         chk(tbl[i].tag, {en1, busy1, done1, c1},
             {tbl[i].e_en, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_c});
      end
      start1 = 0; pausa = 0; abortar = 0;
      step();

      // ---- DIV=4 wrap run 14 -> 2: en on cycles 3,7,11,15 after start ----
      load_c(4'd14);
      start4 = 1; limite = 4'd2;
      step();
      start4 = 0;
      for (int k = 0; k < 20; k++) begin
         int st;
         logic [3:0] ec;
         st = (k / 4 > 4) ? 4 : k / 4;
         ec = 4'(14 + st);
         chk($sformatf("div4_k%0d", k), {en4, busy4, done4, c4},
             {(k % 4 == 3) && (k < 16), k <= 16, k == 17, ec});
         step();
      end

      // ---- DIV=2 run 0 -> 12 with pausa on edges 6..15 ----
      load_c(4'd0);
      start2 = 1; limite = 4'd12;
      step();
      start2 = 0;
      for (int k = 0; k < 38; k++) begin
         int st;
         logic ee;
         if (k < 16) st = (k / 2 > 3) ? 3 : k / 2;
         else        st = (3 + (k - 16) / 2 > 12) ? 12 : 3 + (k - 16) / 2;
         ee = ((k < 6) || (k >= 17 && k <= 33)) && (k % 2 == 1);
         chk($sformatf("div2p_k%0d", k), {en2, busy2, done2, c2},
             {ee, k <= 34, k == 35, 4'(st)});
         pausa = (k >= 5 && k <= 14);
         step();
      end
      pausa = 0;

      // ---- DIV=2 abort after 2 steps ----
      load_c(4'd0);
      start2 = 1; limite = 4'd12;
      step();
      start2 = 0;
      for (int k = 0; k < 8; k++) begin
         logic [3:0] ec;
         ec = (k < 2) ? 4'd0 : (k < 4) ? 4'd1 : 4'd2;
         chk($sformatf("div2a_k%0d", k), {en2, busy2, done2, c2},
             {(k == 1) || (k == 3), k <= 3, 1'b0, ec});
         abortar = (k == 3);
         step();
      end
      abortar = 0;

      // ---- reset mid-run (DIV=1) ----
      load_c(4'd0);
      start1 = 1; limite = 4'd10;
      step();
      start1 = 0;
      step();
      step();
      chk("rstrun_pre", {en1, busy1, done1, c1}, {1'b1, 1'b1, 1'b0, 4'd2});
      rst = 1;
      step();
      chk("rstrun_edge", {en1, busy1, done1, c1}, {1'b0, 1'b0, 1'b0, 4'd3});
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rstrun_after%0d", k), {en1, busy1, done1, c1},
             {1'b0, 1'b0, 1'b0, 4'd3});
      end

`ifdef CONTROL_CONTADOR_STEP_EN
      // ---- single step in PAUSE (DIV=2): 7 -> 8, second pulse ignored ----
      load_c(4'd7);
      start2 = 1; limite = 4'd8; pausa = 1;
      step();
      start2 = 0;
      chk("step_run", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd7});
      step();
      chk("step_paused", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd7});
      paso = 1;
      step();
      chk("step_en", {en2, busy2, done2, c2}, {1'b1, 1'b1, 1'b0, 4'd7});
      paso = 0;
      step();
      chk("step_reached", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd8});
      step();
      paso = 1;
      step();
      chk("step2_ignored", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd8});
      step();
      chk("step2_held", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd8});
      paso = 0;
      pausa = 0;
      step();
      chk("step_resume", {en2, busy2, done2, c2}, {1'b0, 1'b1, 1'b0, 4'd8});
      step();
      chk("step_done", {en2, busy2, done2, c2}, {1'b0, 1'b0, 1'b1, 4'd8});
      step();
      chk("step_idle", {en2, busy2, done2, c2}, {1'b0, 1'b0, 1'b0, 4'd8});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
